// File: rtl/bioz_siggen_pkg.sv
// Shared types for the BioZ excitation DAC sequencer:
// FSM states, StepSel encodings and the StepSel -> stride lookup.
package bioz_siggen_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [1:0] STEP_X1     = 2'b00;
    localparam logic [1:0] STEP_X2     = 2'b01;
    localparam logic [1:0] STEP_X4     = 2'b10;
    localparam logic [1:0] STEP_X1_ALT = 2'b11;

    function automatic logic [2:0] stride_of(input logic [1:0] sel);
        logic [2:0] s;
        s = 3'd1;
        unique case (sel)
            STEP_X1:     s = 3'd1;
            STEP_X2:     s = 3'd2;
            STEP_X4:     s = 3'd4;
            STEP_X1_ALT: s = 3'd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bioz_siggen_phase_decode.sv
// Phase -> one-hot DAC level and I/Q reference decode (combinational).
// Ports: phase (in), idle (in, forces midscale), p (one-hot), ip, qp.
module bioz_siggen_phase_decode
    import bioz_siggen_pkg::*;
#(
    parameter int LEVELS = 8
) (
    input  logic [$clog2(4*LEVELS)-1:0] phase,
    input  logic                        idle,
    output logic [2*LEVELS:0]           p,
    output logic                        ip,
    output logic                        qp
);

    localparam int PHW = $clog2(4*LEVELS);
    localparam int IW  = PHW - 2;
    localparam int PW  = 2*LEVELS + 1;
    localparam int BW  = $clog2(PW);
    localparam logic [IW:0]   LV_M = LEVELS[IW:0];
    localparam logic [BW-1:0] LV_B = LEVELS[BW-1:0];

    logic [1:0]    q;
    logic [IW-1:0] idx;
    logic [IW:0]   m;
    logic [BW-1:0] pos;

    assign q   = phase[PHW-1:PHW-2];
    assign idx = phase[IW-1:0];

    always_comb begin
        // Odd quadrants walk the magnitude back down from the peak.
        m   = q[0] ? (LV_M - {1'b0, idx}) : {1'b0, idx};
        pos = '0;
        if (m != '0) begin
            pos = q[1] ? (LV_B + BW'(m)) : BW'(m);
        end
        p  = PW'(1);
        ip = 1'b0;
        qp = 1'b0;
        if (!idle) begin
            p  = PW'(1) << pos;
            ip = ~q[1];
            qp = q[1] ^ q[0];
        end
    end

endmodule

// File: rtl/bioz_siggen_dacctrl_param.sv
// BioZ excitation DAC sequencer: prescaled phase counter, stride select,
// graceful zero-crossing stop, registered one-hot P and I/Q references.
// Ports: Clk, Resetn, Enable, StepSel, DivRatio -> P, IP/IN, QP/QN,
// Running, PeriodDone.
module bioz_siggen_dacctrl_param
    import bioz_siggen_pkg::*;
#(
    parameter int LEVELS = 8,
    parameter int DIV_W  = 8
) (
    input  logic               Clk,
    input  logic               Resetn,
    input  logic               Enable,
    input  logic [1:0]         StepSel,
    input  logic [DIV_W-1:0]   DivRatio,
    output logic [2*LEVELS:0]  P,
    output logic               IP,
    output logic               IN,
    output logic               QP,
    output logic               QN,
    output logic               Running,
    output logic               PeriodDone
);

    localparam int PHW = $clog2(4*LEVELS);
    localparam int PW  = 2*LEVELS + 1;

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [PHW-1:0]   phase;
    logic [PHW-1:0]   phase_nx;
    logic [2:0]       stride;
    logic             active;
    logic             tick;
    logic             wrap;
    logic             wrapped;
    logic [PW-1:0]    p_dec;
    logic             ip_dec;
    logic             qp_dec;

    assign active   = (state != IDLE);
    assign tick     = active && (presc == DivRatio);
    assign phase_nx = phase + PHW'(stride);
    assign wrap     = tick && (phase_nx == '0);

    bioz_siggen_phase_decode #(
        .LEVELS(LEVELS)
    ) u_dec (
        .phase(phase),
        .idle (!active),
        .p    (p_dec),
        .ip   (ip_dec),
        .qp   (qp_dec)
    );

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            presc   <= '0;
            phase   <= '0;
            stride  <= 3'd1;
            wrapped <= 1'b0;
        end else begin
            wrapped <= wrap;
            if (tick) begin
                phase <= phase_nx;
            end
            // A shrinking DivRatio below presc lets presc roll over at max.
            if (!active || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            // Stride only changes at a period boundary.
            if ((!active && Enable) || wrap) begin
                stride <= stride_of(StepSel);
            end
            unique case (state)
                IDLE: begin
                    if (Enable) state <= RUN;
                end
                RUN: begin
                    if (!Enable) state <= STOPPING;
                end
                STOPPING: begin
                    if (Enable) state <= RUN;
                    else if (wrap) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage lags the phase register by one cycle.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            P          <= PW'(1);
            IP         <= 1'b0;
            QP         <= 1'b0;
            Running    <= 1'b0;
            PeriodDone <= 1'b0;
        end else begin
            P          <= p_dec;
            IP         <= ip_dec;
            QP         <= qp_dec;
            Running    <= active;
            PeriodDone <= wrapped;
        end
    end

    assign IN = ~IP;
    assign QN = ~QP;

endmodule
